// File: rtl/serv_pkg.sv
// serv_pkg: shared definitions for the W-bit-per-cycle sequencing slice.
//   state_e        FSM states of serv_state_wide (encoding is visible on o_state)
//   OP_*           bit positions inside the i_op bundle
//   CNT_W          width of the bit-position counter
//   w_is_legal()   legal datapath widths (1, 2, 4, 8)
package serv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DECODE = 3'd1,
      ST_INIT   = 3'd2,
      ST_WAIT2  = 3'd3,
      ST_RUN    = 3'd4
   } state_e;

   // i_op = {e_op, rd_op, mem_op, shift_op, sh_right, slt_op, branch_op}
   localparam int OP_BRANCH   = 0;
   localparam int OP_SLT      = 1;
   localparam int OP_SH_RIGHT = 2;
   localparam int OP_SHIFT    = 3;
   localparam int OP_MEM      = 4;
   localparam int OP_RD       = 5;
   localparam int OP_E        = 6;
   localparam int OP_W        = 7;

   localparam int CNT_W = 5;

   function automatic bit w_is_legal(input int w);
      case (w)
         1, 2, 4, 8: return 1'b1;
         default:    return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/serv_cnt.sv
// serv_cnt: bit-position counter for one 32-bit phase processed W bits per cycle.
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_start        begin a phase (ignored while a phase is already running)
//   o_cnt          bit index of the LSB of the current W-bit chunk
//   o_cnt_en       phase running; high for exactly 32/W cycles
//   o_cnt_done     last step of the phase (combinational)
module serv_cnt
   import serv_pkg::*;
#(
   parameter int W = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_cnt_en,
   output logic             o_cnt_done
);

   // An unsupported width degrades to the bit-serial step instead of never finishing.
   localparam int STEP = w_is_legal(W) ? W : 1;
   localparam logic [CNT_W-1:0] STEP_V = CNT_W'(STEP);
   localparam logic [CNT_W-1:0] LAST_V = CNT_W'(32 - STEP);

   logic [CNT_W-1:0] cnt_r;
   logic             cnt_en_r;

   // Step the position; the natural 5-bit wrap brings it back to 0 after the last chunk.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_r    <= {CNT_W{1'b0}};
         cnt_en_r <= 1'b0;
      end else begin
         if (cnt_en_r) begin
            cnt_r <= cnt_r + STEP_V;
         end else begin
            cnt_r <= cnt_r;
         end
         if (o_cnt_done) begin
            cnt_en_r <= 1'b0;
         end else if (i_start) begin
            cnt_en_r <= 1'b1;
         end else begin
            cnt_en_r <= cnt_en_r;
         end
      end
   end

   assign o_cnt      = cnt_r;
   assign o_cnt_en   = cnt_en_r;
   assign o_cnt_done = cnt_en_r & (cnt_r == LAST_V);

endmodule

// File: rtl/serv_state_wide.sv
// serv_state_wide: instruction sequencing for the serial RISC-V core at W bits/cycle.
// Flow: IDLE (fetch) -> DECODE -> [INIT -> WAIT2] -> RUN -> IDLE.
// Parameters: W (1,2,4,8), RESET_STRATEGY ("NONE" leaves decision latches unreset),
//             WITH_CSR (0 disables all trap generation).
// Ports: ibus/dbus request+ack, RF read/write prepare strobes and ready, decoded op
//        bundle i_op, ALU compare/misalign inputs, shifter done; outputs the state,
//        counter (o_cnt/o_cnt_en/o_cnt_done), PC/jump/trap controls, rd enable,
//        byte count and bufreg enable.
// Optional macro SERV_STATE_MDU_EN adds i_mdu_op/o_mdu_valid/i_mdu_ready; without it
// multiply/divide instructions reach this block as illegal (e_op) instructions.
module serv_state_wide
   import serv_pkg::*;
#(
   parameter int W              = 1,
   parameter     RESET_STRATEGY = "MINI",
   parameter int WITH_CSR       = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_new_irq,
   output logic             o_ibus_cyc,
   input  logic             i_ibus_ack,
   output logic             o_dbus_cyc,
   input  logic             i_dbus_ack,
   output logic             o_rf_rreq,
   output logic             o_rf_wreq,
   input  logic             i_rf_ready,
   input  logic [OP_W-1:0]  i_op,
   input  logic             i_cond_branch,
   input  logic             i_bne_or_bge,
   input  logic             i_alu_cmp,
   input  logic             i_ctrl_misalign,
   input  logic             i_mem_misalign,
   input  logic             i_sh_done,
`ifdef SERV_STATE_MDU_EN
   input  logic             i_mdu_op,
   output logic             o_mdu_valid,
   input  logic             i_mdu_ready,
`endif
   output logic [2:0]       o_state,
   output logic             o_init,
   output logic             o_cnt_en,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_cnt_done,
   output logic             o_ctrl_pc_en,
   output logic             o_ctrl_jump,
   output logic             o_ctrl_trap,
   output logic             o_rf_rd_en,
   output logic [1:0]       o_mem_bytecnt,
   output logic             o_bufreg_en
);

   localparam bit RST_ALL = (RESET_STRATEGY != "NONE");
   localparam bit CSR_EN  = (WITH_CSR != 0);

   state_e           state_r, state_s;
   logic             ibus_cyc_r, trap_r, done_r, jump_r, trap_sync_r, sh_done_r;
   logic             rreq_s, wreq_s, dbus_cyc_s, start_s, strobe_s;
   logic             cnt_en_s, cnt_done_s, two_stage_s, jump_s, trap_sync_s;
   logic             fetch_ack_s, init_end_s, run_start_s, run_end_s, irq_s;
   logic [CNT_W-1:0] cnt_s;
`ifdef SERV_STATE_MDU_EN
   logic             mdu_valid_s;
`endif

   serv_cnt #(.W(W)) u_cnt (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_start    (start_s),
      .o_cnt      (cnt_s),
      .o_cnt_en   (cnt_en_s),
      .o_cnt_done (cnt_done_s)
   );

`ifdef SERV_STATE_MDU_EN
   assign two_stage_s = i_op[OP_SLT] | i_op[OP_MEM] | i_op[OP_BRANCH] | i_op[OP_SHIFT] | i_mdu_op;
`else
   assign two_stage_s = i_op[OP_SLT] | i_op[OP_MEM] | i_op[OP_BRANCH] | i_op[OP_SHIFT];
`endif
   // i_alu_cmp is only meaningful on the last INIT step, which is when this is latched.
   assign jump_s      = i_op[OP_BRANCH] & (~i_cond_branch | (i_alu_cmp ^ i_bne_or_bge));
   assign trap_sync_s = CSR_EN & ((jump_s & i_ctrl_misalign) | (i_op[OP_MEM] & i_mem_misalign));
   // irq only counts when sampled at the DECODE->execute decision; later irqs wait.
   assign irq_s       = (state_r == ST_DECODE) & i_new_irq;
   assign fetch_ack_s = (state_r == ST_IDLE) & ibus_cyc_r & i_ibus_ack;
   assign init_end_s  = (state_r == ST_INIT) & cnt_done_s;
   assign run_end_s   = (state_r == ST_RUN) & cnt_done_s;
   assign run_start_s = start_s & (state_s == ST_RUN);

   // Next-state and WAIT2 handshakes; done_r makes each WAIT2 strobe single-shot.
   always_comb begin
      state_s    = state_r;
      rreq_s     = 1'b0;
      wreq_s     = 1'b0;
      dbus_cyc_s = 1'b0;
      start_s    = 1'b0;
      strobe_s   = 1'b0;
`ifdef SERV_STATE_MDU_EN
      mdu_valid_s = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (fetch_ack_s) begin
               rreq_s  = 1'b1;
               state_s = ST_DECODE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_DECODE: begin
            if (i_rf_ready) begin
               start_s = 1'b1;
               state_s = (two_stage_s & ~i_new_irq) ? ST_INIT : ST_RUN;
            end else begin
               state_s = ST_DECODE;
            end
         end
         ST_INIT: begin
            if (cnt_done_s) begin
               state_s = ST_WAIT2;
            end else begin
               state_s = ST_INIT;
            end
         end
         ST_WAIT2: begin
            if (!done_r) begin
               if (trap_sync_r) begin
                  rreq_s   = 1'b1;
                  strobe_s = 1'b1;
               end
`ifdef SERV_STATE_MDU_EN
               else if (i_mdu_op) begin
                  mdu_valid_s = 1'b1;
                  if (i_mdu_ready) begin
                     wreq_s   = 1'b1;
                     strobe_s = 1'b1;
                  end else begin
                     wreq_s   = 1'b0;
                  end
               end
`endif
               else if (i_op[OP_MEM]) begin
                  dbus_cyc_s = 1'b1;
                  if (i_dbus_ack) begin
                     wreq_s   = 1'b1;
                     strobe_s = 1'b1;
                  end else begin
                     wreq_s   = 1'b0;
                  end
               end else if (i_op[OP_SHIFT]) begin
                  if (i_sh_done | ~i_op[OP_SH_RIGHT]) begin
                     wreq_s   = 1'b1;
                     strobe_s = 1'b1;
                  end else begin
                     wreq_s   = 1'b0;
                  end
               end else begin
                  wreq_s   = 1'b1;
                  strobe_s = 1'b1;
               end
               state_s = ST_WAIT2;
            end else if (i_rf_ready) begin
               start_s = 1'b1;
               state_s = ST_RUN;
            end else begin
               state_s = ST_WAIT2;
            end
         end
         ST_RUN: begin
            if (cnt_done_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RUN;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Sequencing state is reset under every strategy so the core always restarts with a fetch.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r    <= ST_IDLE;
         ibus_cyc_r <= 1'b1;
         trap_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r <= state_s;
         if (run_end_s) begin
            ibus_cyc_r <= 1'b1;
         end else if (fetch_ack_s) begin
            ibus_cyc_r <= 1'b0;
         end else begin
            ibus_cyc_r <= ibus_cyc_r;
         end
         if (run_end_s) begin
            trap_r <= 1'b0;
         end else if (run_start_s) begin
            trap_r <= CSR_EN & (i_op[OP_E] | irq_s | trap_sync_r);
         end else begin
            trap_r <= trap_r;
         end
         if (init_end_s) begin
            done_r <= 1'b0;
         end else if (strobe_s) begin
            done_r <= 1'b1;
         end else begin
            done_r <= done_r;
         end
      end
   end

   // Branch/trap decisions captured at the end of INIT and held until RUN completes.
   always_ff @(posedge i_clk) begin
      if (RST_ALL && i_rst) begin
         jump_r      <= 1'b0;
         trap_sync_r <= 1'b0;
         sh_done_r   <= 1'b0;
      end else begin
         if (init_end_s) begin
            jump_r      <= jump_s;
            trap_sync_r <= trap_sync_s;
         end else if (run_end_s) begin
            jump_r      <= 1'b0;
            trap_sync_r <= 1'b0;
         end else begin
            jump_r      <= jump_r;
            trap_sync_r <= trap_sync_r;
         end
         sh_done_r <= i_sh_done;
      end
   end

   // Strobes are suppressed while reset is asserted so an abort never leaks a request.
   assign o_rf_rreq     = rreq_s & ~i_rst;
   assign o_rf_wreq     = wreq_s & ~i_rst;
   assign o_dbus_cyc    = dbus_cyc_s & ~i_rst;
   assign o_cnt_done    = cnt_done_s & ~i_rst;
`ifdef SERV_STATE_MDU_EN
   assign o_mdu_valid   = mdu_valid_s & ~i_rst;
`endif
   assign o_ibus_cyc    = ibus_cyc_r;
   assign o_state       = state_r;
   assign o_init        = (state_r == ST_INIT);
   assign o_cnt_en      = cnt_en_s;
   assign o_cnt         = cnt_s;
   assign o_ctrl_pc_en  = cnt_en_s & ~o_init;
   assign o_ctrl_jump   = jump_r;
   assign o_ctrl_trap   = trap_r;
   assign o_rf_rd_en    = i_op[OP_RD] & ~o_init;
   assign o_mem_bytecnt = cnt_s[4:3];
   assign o_bufreg_en   = (cnt_en_s & (o_init | trap_r | i_op[OP_BRANCH])) |
                          (i_op[OP_SHIFT] & (state_r == ST_WAIT2) & (i_op[OP_SH_RIGHT] | sh_done_r));

endmodule

// File: tb/tb_serv_state_wide.sv
// Randomised instruction-level bench for serv_state_wide (W=2, WITH_CSR=1).
module tb_serv_state_wide;

   localparam int W     = 2;
   localparam int STEPS = 32 / W;
   localparam logic [2:0] S_IDLE = 3'd0, S_DECODE = 3'd1, S_INIT = 3'd2,
                          S_WAIT2 = 3'd3, S_RUN = 3'd4;

   logic       i_clk = 1'b0;
   logic       i_rst, i_new_irq, i_ibus_ack, i_dbus_ack, i_rf_ready;
   logic [6:0] i_op;
   logic       i_cond_branch, i_bne_or_bge, i_alu_cmp, i_ctrl_misalign, i_mem_misalign, i_sh_done;
   logic       o_ibus_cyc, o_dbus_cyc, o_rf_rreq, o_rf_wreq, o_init, o_cnt_en, o_cnt_done;
   logic       o_ctrl_pc_en, o_ctrl_jump, o_ctrl_trap, o_rf_rd_en, o_bufreg_en;
   logic [2:0] o_state;
   logic [4:0] o_cnt;
   logic [1:0] o_mem_bytecnt;
`ifdef SERV_STATE_MDU_EN
   logic       i_mdu_op = 1'b0, i_mdu_ready = 1'b0, o_mdu_valid;
`endif

   int n_vec = 0;
   int n_err = 0;
   bit prev_sh = 1'b0;

   always #5 i_clk = ~i_clk;

   serv_state_wide #(.W(W), .RESET_STRATEGY("MINI"), .WITH_CSR(1)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_new_irq(i_new_irq),
      .o_ibus_cyc(o_ibus_cyc), .i_ibus_ack(i_ibus_ack),
      .o_dbus_cyc(o_dbus_cyc), .i_dbus_ack(i_dbus_ack),
      .o_rf_rreq(o_rf_rreq), .o_rf_wreq(o_rf_wreq), .i_rf_ready(i_rf_ready),
      .i_op(i_op), .i_cond_branch(i_cond_branch), .i_bne_or_bge(i_bne_or_bge),
      .i_alu_cmp(i_alu_cmp), .i_ctrl_misalign(i_ctrl_misalign),
      .i_mem_misalign(i_mem_misalign), .i_sh_done(i_sh_done),
`ifdef SERV_STATE_MDU_EN
      .i_mdu_op(i_mdu_op), .o_mdu_valid(o_mdu_valid), .i_mdu_ready(i_mdu_ready),
`endif
      .o_state(o_state), .o_init(o_init), .o_cnt_en(o_cnt_en), .o_cnt(o_cnt),
      .o_cnt_done(o_cnt_done), .o_ctrl_pc_en(o_ctrl_pc_en), .o_ctrl_jump(o_ctrl_jump),
      .o_ctrl_trap(o_ctrl_trap), .o_rf_rd_en(o_rf_rd_en),
      .o_mem_bytecnt(o_mem_bytecnt), .o_bufreg_en(o_bufreg_en)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic tick();
      prev_sh = i_sh_done;
      @(posedge i_clk);
      #1;
   endtask

   task automatic rnd_irq();
      i_new_irq = ($urandom_range(0, 5) == 0);
   endtask

   // cls: 0 ADD, 1 cond branch, 2 JAL, 3 SLT, 4 shift, 5 load, 6 store, 7 ecall
   task automatic run_instr(input int cls, input bit abort);
      bit br, cond, slt, sh, shr, mem, rd, e, cmp, bne, cmis, mmis;
      bit irq, two, jmp, ts, trp;
      int n, d;
      br = 0; cond = 0; slt = 0; sh = 0; shr = 0; mem = 0; rd = 0; e = 0;
      case (cls)
         0: rd = 1;
         1: begin br = 1; cond = 1; end
         2: begin br = 1; rd = 1; end
         3: begin slt = 1; rd = 1; end
         4: begin sh = 1; rd = 1; shr = ($urandom_range(0, 1) == 1); end
         5: begin mem = 1; rd = 1; end
         6: mem = 1;
         default: e = 1;
      endcase
      cmp  = ($urandom_range(0, 1) == 1);
      bne  = ($urandom_range(0, 1) == 1);
      cmis = ($urandom_range(0, 3) == 0);
      mmis = ($urandom_range(0, 3) == 0);
      i_op = {e, rd, mem, sh, shr, slt, br};
      i_cond_branch = cond; i_bne_or_bge = bne; i_alu_cmp = cmp;
      i_ctrl_misalign = cmis; i_mem_misalign = mmis;
      i_sh_done = 0; i_dbus_ack = 0; i_rf_ready = 0; i_ibus_ack = 0;

      n = $urandom_range(0, 2);
      for (int c = 0; c <= n; c++) begin
         rnd_irq();
         i_ibus_ack = (c == n);
         #1;
         check("idle_state", 32'(o_state), 32'(S_IDLE));
         check("idle_ibus_cyc", 32'(o_ibus_cyc), 32'd1);
         check("idle_cnt", 32'(o_cnt), 32'd0);
         check("idle_cnt_en", 32'(o_cnt_en), 32'd0);
         check("idle_jump", 32'(o_ctrl_jump), 32'd0);
         check("idle_trap", 32'(o_ctrl_trap), 32'd0);
         check("fetch_rreq", 32'(o_rf_rreq), 32'(c == n));
         tick();
      end
      i_ibus_ack = 0;

      n = $urandom_range(0, 2);
      for (int c = 0; c <= n; c++) begin
         rnd_irq();
         i_rf_ready = (c == n);
         if (c == n) irq = i_new_irq;
         #1;
         check("dec_state", 32'(o_state), 32'(S_DECODE));
         check("dec_ibus_cyc", 32'(o_ibus_cyc), 32'd0);
         check("dec_cnt_en", 32'(o_cnt_en), 32'd0);
         check("dec_rreq", 32'(o_rf_rreq), 32'd0);
         check("dec_bufreg", 32'(o_bufreg_en), 32'd0);
         tick();
      end
      i_rf_ready = 0;

      two = (slt | mem | br | sh) & !irq;
      jmp = two & br & (!cond | (cmp ^ bne));
      ts  = two & ((jmp & cmis) | (mem & mmis));
      trp = e | irq | ts;

      if (two) begin
         for (int k = 0; k < STEPS; k++) begin
            i_rf_ready = ($urandom_range(0, 1) == 1);
            rnd_irq();
            #1;
            check("init_state", 32'(o_state), 32'(S_INIT));
            check("init_flag", 32'(o_init), 32'd1);
            check("init_cnt_en", 32'(o_cnt_en), 32'd1);
            check("init_cnt", 32'(o_cnt), 32'(k * W));
            check("init_done", 32'(o_cnt_done), 32'(k == STEPS - 1));
            check("init_pc_en", 32'(o_ctrl_pc_en), 32'd0);
            check("init_bufreg", 32'(o_bufreg_en), 32'd1);
            check("init_rd_en", 32'(o_rf_rd_en), 32'd0);
            tick();
         end
         i_rf_ready = 0;

         if (ts || (!mem && !(sh && shr))) d = 0;
         else d = $urandom_range(0, 4);
         for (int c = 0; c <= d; c++) begin
            rnd_irq();
            i_dbus_ack = mem & !ts & (c == d);
            if (sh && shr) i_sh_done = (c == d);
            #1;
            check("w2_state", 32'(o_state), 32'(S_WAIT2));
            check("w2_cnt_en", 32'(o_cnt_en), 32'd0);
            check("w2_dbus_cyc", 32'(o_dbus_cyc), 32'(mem & !ts));
            check("w2_rreq", 32'(o_rf_rreq), 32'(ts && c == d));
            check("w2_wreq", 32'(o_rf_wreq), 32'(!ts && c == d));
            check("w2_bufreg", 32'(o_bufreg_en), 32'(sh & (shr | prev_sh)));
            tick();
         end
         i_dbus_ack = 0;

         n = $urandom_range(0, 2);
         for (int c = 0; c <= n; c++) begin
            rnd_irq();
            i_rf_ready = (c == n);
            #1;
            check("w2_hold_state", 32'(o_state), 32'(S_WAIT2));
            check("w2_hold_rreq", 32'(o_rf_rreq), 32'd0);
            check("w2_hold_wreq", 32'(o_rf_wreq), 32'd0);
            check("w2_hold_dbus", 32'(o_dbus_cyc), 32'd0);
            tick();
         end
         i_rf_ready = 0;
      end

      for (int k = 0; k < STEPS; k++) begin
         i_rf_ready = ($urandom_range(0, 1) == 1);
         rnd_irq();
         #1;
         check("run_state", 32'(o_state), 32'(S_RUN));
         check("run_cnt_en", 32'(o_cnt_en), 32'd1);
         check("run_cnt", 32'(o_cnt), 32'(k * W));
         check("run_done", 32'(o_cnt_done), 32'(k == STEPS - 1));
         check("run_pc_en", 32'(o_ctrl_pc_en), 32'd1);
         check("run_jump", 32'(o_ctrl_jump), 32'(jmp));
         check("run_trap", 32'(o_ctrl_trap), 32'(trp));
         check("run_rd_en", 32'(o_rf_rd_en), 32'(rd));
         check("run_bytecnt", 32'(o_mem_bytecnt), 32'((k * W) >> 3));
         check("run_bufreg", 32'(o_bufreg_en), 32'(trp | br));
         if (abort && k * W == 12) begin
            i_rst = 1;
            i_rf_ready = 0;
            tick();
            i_ibus_ack = 1;
            #1;
            check("abort_state", 32'(o_state), 32'(S_IDLE));
            check("abort_cnt", 32'(o_cnt), 32'd0);
            check("abort_cnt_en", 32'(o_cnt_en), 32'd0);
            check("abort_rreq", 32'(o_rf_rreq), 32'd0);
            check("abort_jump", 32'(o_ctrl_jump), 32'd0);
            check("abort_trap", 32'(o_ctrl_trap), 32'd0);
            tick();
            i_rst = 0;
            i_ibus_ack = 0;
            i_sh_done = 0;
            #1;
            check("abort_rel_state", 32'(o_state), 32'(S_IDLE));
            check("abort_rel_ibus_cyc", 32'(o_ibus_cyc), 32'd1);
            return;
         end
         tick();
      end
      i_rf_ready = 0;
      i_sh_done = 0;
   endtask

   initial begin
      i_rst = 1; i_new_irq = 0; i_ibus_ack = 0; i_dbus_ack = 0; i_rf_ready = 0;
      i_op = 7'd0; i_cond_branch = 0; i_bne_or_bge = 0; i_alu_cmp = 0;
      i_ctrl_misalign = 0; i_mem_misalign = 0; i_sh_done = 0;
      tick();
      i_ibus_ack = 1;
      #1;
      check("rst_rreq", 32'(o_rf_rreq), 32'd0);
      check("rst_state", 32'(o_state), 32'(S_IDLE));
      check("rst_cnt", 32'(o_cnt), 32'd0);
      check("rst_cnt_en", 32'(o_cnt_en), 32'd0);
      check("rst_jump", 32'(o_ctrl_jump), 32'd0);
      check("rst_trap", 32'(o_ctrl_trap), 32'd0);
      check("rst_wreq", 32'(o_rf_wreq), 32'd0);
      check("rst_dbus", 32'(o_dbus_cyc), 32'd0);
      tick();
      i_rst = 0;
      i_ibus_ack = 0;
      #1;
      check("rel_state", 32'(o_state), 32'(S_IDLE));
      check("rel_ibus_cyc", 32'(o_ibus_cyc), 32'd1);
      for (int i = 0; i < 48; i++) begin
         run_instr((i < 8) ? i : int'($urandom_range(0, 7)), i == 20);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
